// File: rtl/prism_shift_fifo.sv
// prism_shift_fifo: serial shifter plus circular word FIFO between the PRISM FSM and the CPU bus.
//   RX (mode=0): shift strobes assemble serial_in bits into words that are pushed into the FIFO.
//                The CPU pops the words through cpu_rd / cpu_rdata.
//   TX (mode=1): the CPU pushes words with cpu_wr. The shifter loads the FIFO head and serialises it
//                onto serial_out.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   enable, shift        shift qualifier and one-bit-per-cycle strobe
//   clear                synchronous flush of the FIFO, the shifter and the sticky flags
//   mode, msb_first      direction select and bit order
//   serial_in/out        serial data
//   word_done            one-cycle pulse after the shifter completes a word
//   cpu_wr/wdata         CPU push (TX only)
//   cpu_rd/rdata         CPU pop (RX only); rdata is the FIFO head, 0 when empty
//   thresh, irq          level threshold and interrupt
//   level, full, empty   FIFO occupancy
//   overflow, underrun   sticky error flags
module prism_shift_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter logic        IDLE_LEVEL = 1'b1,
    localparam int unsigned LW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             mode,
    input  logic             msb_first,
    input  logic             shift,
    input  logic             serial_in,
    output logic             serial_out,
    output logic             word_done,
    input  logic             cpu_wr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic             cpu_rd,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic [LW-1:0]    thresh,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underrun,
    output logic             irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned BW = $clog2(WIDTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             mode_q;
    logic [PW-1:0]    wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [BW-1:0]    bit_cnt, bit_cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             tx_loaded, tx_loaded_d;
    logic             word_done_q, word_done_d;
    logic             overflow_q, overflow_d;
    logic             underrun_q, underrun_d;

    logic             flush, shift_en, last_bit, fifo_empty, fifo_full, tx_load;
    logic             push_req, pop_req, push_ok, pop_ok, mem_we;
    logic [WIDTH-1:0] push_data, rx_shifted, tx_shifted;

    // Datapath helpers and FIFO handshake decisions
    always_comb begin
        flush      = clear | (mode != mode_q);
        shift_en   = enable & shift;
        last_bit   = (bit_cnt == BW'(WIDTH - 1));
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LW'(DEPTH));
        rx_shifted = msb_first ? {shreg[WIDTH-2:0], serial_in} : {serial_in, shreg[WIDTH-1:1]};
        tx_shifted = msb_first ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        // Head load is a shifter action, so it is frozen along with shifting when enable is low
        tx_load    = mode_q & enable & ~tx_loaded & ~fifo_empty;
        push_req   = mode_q ? cpu_wr : (shift_en & last_bit);
        push_data  = mode_q ? cpu_wdata : rx_shifted;
        pop_req    = mode_q ? tx_load : cpu_rd;
        pop_ok     = pop_req & ~fifo_empty;
        // A simultaneous pop frees the slot, so a push at full still lands
        push_ok    = push_req & (~fifo_full | pop_ok);
        mem_we     = ~flush & push_ok;
    end

    // Next-state logic
    always_comb begin
        wr_ptr_d    = wr_ptr;
        rd_ptr_d    = rd_ptr;
        level_d     = level_q;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;
        tx_loaded_d = tx_loaded;
        word_done_d = 1'b0;
        overflow_d  = overflow_q;
        underrun_d  = underrun_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            bit_cnt_d   = '0;
            shreg_d     = '0;
            tx_loaded_d = 1'b0;
            overflow_d  = 1'b0;
            underrun_d  = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr_d = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (push_req & ~push_ok) overflow_d = 1'b1;
            if (!mode_q) begin
                if (shift_en) begin
                    shreg_d     = rx_shifted;
                    bit_cnt_d   = last_bit ? '0 : bit_cnt + BW'(1);
                    word_done_d = last_bit;
                end
            end else begin
                if (tx_load) begin
                    shreg_d     = mem[rd_ptr];
                    tx_loaded_d = 1'b1;
                    bit_cnt_d   = '0;
                end else if (shift_en & tx_loaded) begin
                    shreg_d   = tx_shifted;
                    bit_cnt_d = last_bit ? '0 : bit_cnt + BW'(1);
                    if (last_bit) begin
                        tx_loaded_d = 1'b0;
                        word_done_d = 1'b1;
                    end
                end
                if (shift_en & ~tx_loaded) underrun_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            tx_loaded   <= 1'b0;
            word_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            mode_q      <= mode;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            level_q     <= level_d;
            bit_cnt     <= bit_cnt_d;
            shreg       <= shreg_d;
            tx_loaded   <= tx_loaded_d;
            word_done_q <= word_done_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
        end
    end

    // FIFO storage; contents are qualified by level, so no reset is needed
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= push_data;
    end

    // Outputs
    always_comb begin
        serial_out = tx_loaded ? (msb_first ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;
        cpu_rdata  = fifo_empty ? '0 : mem[rd_ptr];
        word_done  = word_done_q;
        level      = level_q;
        full       = fifo_full;
        empty      = fifo_empty;
        overflow   = overflow_q;
        underrun   = underrun_q;
        irq        = (mode_q ? (level_q <= thresh) : (level_q >= thresh)) | overflow_q | underrun_q;
    end

endmodule

// File: tb/tb_prism_shift_fifo.sv
// Self-checking bench for prism_shift_fifo: a WIDTH=8/DEPTH=4 instance and a DEPTH=3 instance
// driven by the same stimulus. Expected words and bits are kept in scoreboard queues.
module tb_prism_shift_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       clear = 1'b0;
    logic       mode = 1'b0;
    logic       msb_first = 1'b1;
    logic       shift = 1'b0;
    logic       serial_in = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [7:0] cpu_wdata = 8'h00;
    logic       cpu_rd = 1'b0;
    logic [2:0] thresh = 3'd4;
    logic [1:0] thresh3 = 2'd3;

    logic       serial_out, word_done, full, empty, overflow, underrun, irq;
    logic [7:0] cpu_rdata;
    logic [2:0] level;
    logic       d3_serial_out, d3_word_done, d3_full, d3_empty, d3_overflow, d3_underrun, d3_irq;
    logic [7:0] d3_cpu_rdata;
    logic [1:0] d3_level;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] wq[$];
    logic       bq[$];

    typedef struct {
        logic [7:0] data;
        logic       msbf;
        logic [2:0] exp_level;
        logic       exp_irq;
    } rx_vec_t;
    rx_vec_t tbl[4];

    prism_shift_fifo #(.WIDTH(8), .DEPTH(4), .IDLE_LEVEL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .mode(mode),
        .msb_first(msb_first), .shift(shift), .serial_in(serial_in), .serial_out(serial_out),
        .word_done(word_done), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata), .thresh(thresh), .level(level), .full(full), .empty(empty),
        .overflow(overflow), .underrun(underrun), .irq(irq)
    );

    prism_shift_fifo #(.WIDTH(8), .DEPTH(3), .IDLE_LEVEL(1'b1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .mode(mode),
        .msb_first(msb_first), .shift(shift), .serial_in(serial_in), .serial_out(d3_serial_out),
        .word_done(d3_word_done), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd),
        .cpu_rdata(d3_cpu_rdata), .thresh(thresh3), .level(d3_level), .full(d3_full),
        .empty(d3_empty), .overflow(d3_overflow), .underrun(d3_underrun), .irq(d3_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock; leaves the bench 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift one RX word in; optionally pop the head on the final shift cycle
    task automatic rx_word(input logic [7:0] d, input logic msbf, input logic pop_last);
        msb_first = msbf;
        for (int i = 0; i < 8; i++) begin
            serial_in = msbf ? d[3'(7 - i)] : d[3'(i)];
            shift = 1'b1;
            cpu_rd = (i == 7) ? pop_last : 1'b0;
            step();
        end
        shift = 1'b0;
        cpu_rd = 1'b0;
    endtask

    // Pop the head of both instances, comparing against the scoreboard
    task automatic pop_word(input string nm);
        logic [7:0] e;
        e = wq.pop_front();
        chk(nm, 32'(cpu_rdata), 32'(e));
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
    endtask

    task automatic shift_bits(input int n);
        for (int i = 0; i < n; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            shift = 1'b1;
            step();
        end
        shift = 1'b0;
    endtask

    initial begin
        tbl[0] = '{data: 8'hA5, msbf: 1'b1, exp_level: 3'd1, exp_irq: 1'b0};
        tbl[1] = '{data: 8'h3C, msbf: 1'b0, exp_level: 3'd2, exp_irq: 1'b0};
        tbl[2] = '{data: 8'h81, msbf: 1'b1, exp_level: 3'd3, exp_irq: 1'b0};
        tbl[3] = '{data: 8'h7E, msbf: 1'b0, exp_level: 3'd4, exp_irq: 1'b1};

        // Reset values
        #12;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_serial_out", 32'(serial_out), 32'd1);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_flags", 32'({overflow, underrun, word_done, irq}), 32'd0);
        rst_n = 1'b1;
        step();

        // RX fill from the vector table
        foreach (tbl[i]) begin
            rx_word(tbl[i].data, tbl[i].msbf, 1'b0);
            wq.push_back(tbl[i].data);
            chk("rx_word_done", 32'(word_done), 32'd1);
            chk("rx_level", 32'(level), 32'(tbl[i].exp_level));
            chk("rx_head", 32'(cpu_rdata), 32'(wq[0]));
            chk("rx_irq", 32'(irq), 32'(tbl[i].exp_irq));
        end
        step();
        chk("rx_word_done_pulse", 32'(word_done), 32'd0);
        chk("rx_full", 32'(full), 32'd1);

        // Push at full is dropped
        rx_word(8'hFF, 1'b1, 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_irq", 32'(irq), 32'd1);

        // Push and pop in the same cycle while full
        chk("dual_head", 32'(cpu_rdata), 32'(wq.pop_front()));
        rx_word(8'h11, 1'b1, 1'b1);
        wq.push_back(8'h11);
        chk("dual_level", 32'(level), 32'd4);
        chk("dual_ovf_sticky", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) pop_word("drain_data");
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rdata_zero", 32'(cpu_rdata), 32'd0);
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        chk("pop_empty_ignored", 32'({level, overflow}), 32'({3'd0, 1'b1}));

        // Clear mid-word
        shift_bits(5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_flags", 32'({overflow, underrun, word_done}), 32'd0);
        rx_word(8'h5A, 1'b1, 1'b0);
        wq.push_back(8'h5A);
        chk("clr_bitcnt_level", 32'(level), 32'd1);
        pop_word("clr_bitcnt_data");

        // Mode toggle mid-word flushes the partial word
        shift_bits(5);
        mode = 1'b1;
        step();
        mode = 1'b0;
        step();
        chk("modetgl_level", 32'(level), 32'd0);
        chk("modetgl_flags", 32'({overflow, underrun, word_done}), 32'd0);
        rx_word(8'hC3, 1'b0, 1'b0);
        wq.push_back(8'hC3);
        chk("modetgl_bitcnt_level", 32'(level), 32'd1);
        pop_word("modetgl_data");

        // Asynchronous reset mid-word
        rx_word(8'h99, 1'b1, 1'b0);
        shift_bits(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_empty_rdata", 32'({empty, cpu_rdata}), 32'({1'b1, 8'h00}));
        chk("arst_serial_out", 32'(serial_out), 32'd1);
        #1 rst_n = 1'b1;
        step();
        rx_word(8'h24, 1'b1, 1'b0);
        wq.push_back(8'h24);
        chk("arst_after_level", 32'(level), 32'd1);
        pop_word("arst_after_data");

        // RX threshold irq
        thresh = 3'd2;
        rx_word(8'h01, 1'b1, 1'b0);
        wq.push_back(8'h01);
        chk("thr_rx_irq_l1", 32'(irq), 32'd0);
        rx_word(8'h02, 1'b0, 1'b0);
        wq.push_back(8'h02);
        chk("thr_rx_irq_l2", 32'(irq), 32'd1);
        pop_word("thr_rx_data");
        chk("thr_rx_irq_drop", 32'(irq), 32'd0);
        pop_word("thr_rx_data");

        // TX, LSB first
        thresh = 3'd4;
        mode = 1'b1;
        msb_first = 1'b0;
        step();
        cpu_wr = 1'b1;
        cpu_wdata = 8'h3C;
        for (int i = 0; i < 8; i++) bq.push_back(cpu_wdata[3'(i)]);
        step();
        cpu_wdata = 8'h81;
        for (int i = 0; i < 8; i++) bq.push_back(cpu_wdata[3'(i)]);
        step();
        cpu_wr = 1'b0;
        step();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                chk("tx_bit", 32'(serial_out), 32'(bq.pop_front()));
                shift = 1'b1;
                step();
            end
            shift = 1'b0;
            chk("tx_word_done", 32'(word_done), 32'd1);
            step();
        end
        chk("tx_empty", 32'(empty), 32'd1);
        chk("tx_idle_level", 32'(serial_out), 32'd1);
        chk("tx_no_underrun", 32'(underrun), 32'd0);
        shift = 1'b1;
        step();
        shift = 1'b0;
        chk("tx_underrun", 32'(underrun), 32'd1);
        chk("tx_underrun_irq", 32'(irq), 32'd1);
        chk("tx_underrun_serial", 32'(serial_out), 32'd1);

        // TX threshold 0: irq once the FIFO drains
        clear = 1'b1;
        thresh = 3'd0;
        step();
        clear = 1'b0;
        chk("thr_tx_irq_empty", 32'(irq), 32'd1);
        cpu_wr = 1'b1;
        cpu_wdata = 8'h55;
        step();
        cpu_wr = 1'b0;
        chk("thr_tx_irq_l1", 32'(irq), 32'd0);
        step();
        chk("thr_tx_irq_drained", 32'({level, irq}), 32'({3'd0, 1'b1}));

        // Pointer wrap on the DEPTH=3 instance
        mode = 1'b0;
        step();
        chk("wrap_flush", 32'({d3_level, d3_overflow}), 32'd0);
        rx_word(8'h10, 1'b1, 1'b0);
        wq.push_back(8'h10);
        rx_word(8'h21, 1'b0, 1'b0);
        wq.push_back(8'h21);
        for (int k = 0; k < 10; k++) begin
            logic [7:0] d;
            d = 8'(8'h40 + k * 8'h13);
            chk("wrap_head", 32'(d3_cpu_rdata), 32'(wq.pop_front()));
            rx_word(d, 1'(k % 2), 1'b1);
            wq.push_back(d);
            chk("wrap_level", 32'(d3_level), 32'd2);
        end
        for (int i = 0; i < 2; i++) begin
            chk("wrap_drain", 32'(d3_cpu_rdata), 32'(wq[0]));
            pop_word("wrap_drain_main");
        end
        chk("wrap_end", 32'({d3_empty, d3_overflow}), 32'({1'b1, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
